insn_fetch: RTL and testbench
=============================

# insn_fetch

Instruction fetch unit for the stack CPU. It issues word reads to instruction memory and buffers returned words in a 2-entry in-order queue. It presents one instruction at a time, with its address, to the decoder/execute stage. It is the producer end of the `insn` interface: on `load_ip` (jmp, call, ret), it flushes all buffered and in-flight words and refetches from the new IP.

## Interface
- `RESET_IP`, 16'h0000: fetch address after reset; bit 0 ignored.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `mem_addr`  out  16  byte address of the read request; bit 0 always 0.
- `mem_rd`  out  1  read request, one word per cycle asserted.
- `mem_ack`  in  1  read data valid; responses return in request order, at least 1 cycle after the request.
- `mem_rdata`  in  16  read data, sampled when `mem_ack`=1.
- `insn`  out  16  instruction word at queue head.
- `insn_ip`  out  16  byte address of `insn`.
- `insn_valid`  out  1  queue head valid.
- `insn_ready`  in  1  consumer accepts head when `insn_valid`&`insn_ready`.
- `load_ip`  in  1  redirect request; takes effect this cycle.
- `new_ip`  in  16  redirect target; bit 0 cleared internally.

## Operation
- State:
  - `fetch_ip` (16b): next address to request.
  - 2-entry queue of {word, ip}, with `count` 0..2.
  - `outstanding` 0..2: issued, not yet acked.
  - `drop` 0..2: outstanding responses to discard; `drop` ≤ `outstanding`.
- `pop` = `insn_valid` & `insn_ready` & !`load_ip`.
- Issue condition: `mem_rd` = rst released & !`load_ip` & (`count` + `outstanding` − `pop`) < 2.
  - `mem_addr` = `fetch_ip`.
  - On issue: `fetch_ip` += 2, modulo 2^16 (0xFFFE → 0x0000).
  - On issue: `outstanding`++.
- Ack handling: `outstanding`--.
  - If `drop` > 0: `drop`--, data discarded.
  - Otherwise: push {`mem_rdata`, ip of that request} to the queue tail.
  - Each request's ip travels in a 2-entry address FIFO parallel to the outstanding requests.
- Pop: the head advances. Ack and pop in the same cycle are both honoured; `count` is unchanged.
- Redirect (`load_ip`=1):
  - Queue emptied (`count`←0).
  - `fetch_ip` ← {`new_ip`[15:1], 0}.
  - `drop` ← `outstanding` after this cycle's ack.
  - An ack in the same cycle is discarded regardless of `drop`.
  - No issue this cycle.
  - A head presented this cycle is not consumed, even if `insn_ready`=1. The executor owns that instruction's effect.
- The queue never overflows: the issue condition guarantees `count` + `outstanding` ≤ 2 every cycle. An ack while the queue is full cannot occur. The bench checks this with an assertion.

## Timing
- Reset values (while `rst_n`=0, asynchronously):
  - `mem_rd`=0, `mem_addr`=`RESET_IP`&~1.
  - `insn_valid`=0, `insn`=0, `insn_ip`=0.
  - `count`=`outstanding`=`drop`=0.
- First edge with `rst_n`=1 samples `mem_rd`=1 for `RESET_IP` (combinational issue from registered state).
- Ack→valid latency: 1 cycle. Data acked at edge N is on `insn` after edge N; no bypass.
- 1-cycle memory with `insn_ready`=1 sustains 1 instruction/cycle after a 2-cycle startup.
- Redirect penalty with 1-cycle memory:
  - `load_ip` at cycle R.
  - Request for `new_ip` at R+1.
  - Ack at R+2.
  - `insn_valid` at R+3 (after dropped acks, if any).
- Reset asserted mid-operation clears all state immediately. Late acks after reset release are not expected; the memory is reset by the same `rst_n`.

## Test plan
- Reset release, 1-cycle memory returning addr-as-data, `insn_ready`=1 → requests 0x0000, 0x0002, 0x0004… on consecutive cycles. `insn`/`insn_ip` = 0x0000/0x0000, then 0x0002/0x0002… every cycle from the 3rd cycle.
- `insn_ready`=0 for 5 cycles from steady state → exactly 2 words held. `mem_rd` stays low after both slots fill. Releasing ready resumes in order with no gap or duplicate.
- `load_ip`=1, `new_ip`=0x0101 while 2 requests are outstanding → both acks discarded. Next request at 0x0100. `insn_valid` rises only with `insn_ip`=0x0100.
- `load_ip` and `mem_ack` in the same cycle, with `insn_valid`&`insn_ready` → acked word not delivered. Head not consumed. First delivered word comes from `new_ip`.
- `RESET_IP`=16'hFFFE → requests 0xFFFE then 0x0000. `insn_ip` wraps identically.
- `rst_n` pulsed low mid-stream with 2 words queued → `insn_valid` drops asynchronously. After release, fetch restarts at `RESET_IP`.

Source files
------------

// File: rtl/insn_fetch.sv
// rtl/insn_fetch.sv - instruction fetch unit with 2-entry in-order queue and redirect flush
module insn_fetch #(
    parameter logic [15:0] RESET_IP = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] mem_addr,
    output logic        mem_rd,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    output logic [15:0] insn,
    output logic [15:0] insn_ip,
    output logic        insn_valid,
    input  logic        insn_ready,
    input  logic        load_ip,
    input  logic [15:0] new_ip
);

    localparam logic [15:0] START_IP = {RESET_IP[15:1], 1'b0};

    // next word address to request
    logic [15:0] fetch_ip;

    // instruction queue: word + its byte address, head pointer and fill count
    logic [15:0] q_word [2];
    logic [15:0] q_ip   [2];
    logic        q_head;
    logic [1:0]  count;
    logic        q_tail;

    // addresses of in-flight requests, oldest at a_rd
    logic [15:0] a_ip [2];
    logic        a_wr;
    logic        a_rd;
    logic [1:0]  outstanding;
    logic [1:0]  drop;

    logic        pop;
    logic        push;
    logic        issue;
    logic [2:0]  occupancy;

    assign insn_valid = (count != 2'd0);
    assign insn       = q_word[q_head];
    assign insn_ip    = q_ip[q_head];

    // a redirect owns the head this cycle, so it is never consumed alongside load_ip
    assign pop = insn_valid & insn_ready & ~load_ip;

    // slots already claimed (queued + in flight); a pop this cycle frees one
    assign occupancy = {1'b0, count} + {1'b0, outstanding};
    assign issue     = rst_n & ~load_ip & (occupancy < (3'd2 + {2'b00, pop}));
    assign mem_rd    = issue;
    assign mem_addr  = fetch_ip;

    // acks belonging to a flushed stream, or arriving with a redirect, are discarded
    assign push   = mem_ack & ~load_ip & (drop == 2'd0);
    assign q_tail = q_head ^ count[0];

    // fetch address: restart on redirect, advance on every issued request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_ip <= START_IP;
        end else if (load_ip) begin
            fetch_ip <= {new_ip[15:1], 1'b0};
        end else if (issue) begin
            fetch_ip <= fetch_ip + 16'd2;
        end
    end

    // in-flight bookkeeping: request addresses, outstanding count and discard count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_ip[0]     <= 16'h0000;
            a_ip[1]     <= 16'h0000;
            a_wr        <= 1'b0;
            a_rd        <= 1'b0;
            outstanding <= 2'd0;
            drop        <= 2'd0;
        end else begin
            outstanding <= outstanding + {1'b0, issue} - {1'b0, mem_ack};
            if (issue) begin
                a_ip[a_wr] <= fetch_ip;
                a_wr       <= ~a_wr;
            end
            if (mem_ack) begin
                a_rd <= ~a_rd;
            end
            if (load_ip) begin
                drop <= outstanding - {1'b0, mem_ack};
            end else if (mem_ack && (drop != 2'd0)) begin
                drop <= drop - 2'd1;
            end
        end
    end

    // instruction queue: push accepted acks at the tail, pop at the head, flush on redirect
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_word[0] <= 16'h0000;
            q_word[1] <= 16'h0000;
            q_ip[0]   <= 16'h0000;
            q_ip[1]   <= 16'h0000;
            q_head    <= 1'b0;
            count     <= 2'd0;
        end else begin
            if (push) begin
                q_word[q_tail] <= mem_rdata;
                q_ip[q_tail]   <= a_ip[a_rd];
            end
            if (pop) begin
                q_head <= ~q_head;
            end
            if (load_ip) begin
                count <= 2'd0;
            end else begin
                count <= count + {1'b0, push} - {1'b0, pop};
            end
        end
    end

endmodule

// File: tb/tb_insn_fetch.sv
// tb/tb_insn_fetch.sv - directed self-checking bench for insn_fetch
module tb_insn_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic [15:0] insn;
    logic [15:0] insn_ip;
    logic        insn_valid;
    logic        insn_ready;
    logic        load_ip;
    logic [15:0] new_ip;

    logic [15:0] w_addr;
    logic        w_rd;
    logic        w_ack;
    logic [15:0] w_rdata;
    logic [15:0] w_insn;
    logic [15:0] w_insn_ip;
    logic        w_valid;

    int checks = 0;
    int errors = 0;
    logic lat2 = 1'b0;

    always #5 clk = ~clk;

    insn_fetch dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mem_addr   (mem_addr),
        .mem_rd     (mem_rd),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .insn       (insn),
        .insn_ip    (insn_ip),
        .insn_valid (insn_valid),
        .insn_ready (insn_ready),
        .load_ip    (load_ip),
        .new_ip     (new_ip)
    );

    insn_fetch #(.RESET_IP(16'hFFFE)) dut_wrap (
        .clk        (clk),
        .rst_n      (rst_n),
        .mem_addr   (w_addr),
        .mem_rd     (w_rd),
        .mem_ack    (w_ack),
        .mem_rdata  (w_rdata),
        .insn       (w_insn),
        .insn_ip    (w_insn_ip),
        .insn_valid (w_valid),
        .insn_ready (1'b1),
        .load_ip    (1'b0),
        .new_ip     (16'h0000)
    );

    // memory returning address as data, latency 1 or 2
    logic        p1_v, p2_v;
    logic [15:0] p1_a, p2_a;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p1_v <= 1'b0; p2_v <= 1'b0; p1_a <= 16'h0; p2_a <= 16'h0;
        end else begin
            p1_v <= mem_rd; p1_a <= mem_addr;
            p2_v <= p1_v;   p2_a <= p1_a;
        end
    end
    assign mem_ack   = lat2 ? p2_v : p1_v;
    assign mem_rdata = lat2 ? p2_a : p1_a;

    // 1-cycle memory for the wrap instance
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_ack <= 1'b0; w_rdata <= 16'h0;
        end else begin
            w_ack <= w_rd; w_rdata <= w_addr;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // queued plus in-flight words never exceed the two queue slots
    always @(negedge clk) begin
        if (rst_n) check("occupancy", 32'(32'(dut.count) + 32'(dut.outstanding) <= 2), 32'd1);
    end

    initial begin
        logic [15:0] e;
        rst_n = 1'b0; insn_ready = 1'b1; load_ip = 1'b0; new_ip = 16'h0;
        repeat (2) @(negedge clk);

        // reset state
        check("rst_mem_rd", mem_rd, 0);
        check("rst_mem_addr", mem_addr, 16'h0000);
        check("rst_valid", insn_valid, 0);
        check("rst_insn", insn, 0);
        check("rst_insn_ip", insn_ip, 0);
        check("rst_wrap_addr", w_addr, 16'hFFFE);

        // release: first request visible before the first edge
        rst_n = 1'b1; #1;
        check("first_rd", mem_rd, 1);
        check("first_addr", mem_addr, 16'h0000);
        check("wrap_first_addr", w_addr, 16'hFFFE);
        @(negedge clk);
        check("second_addr", mem_addr, 16'h0002);
        check("startup_valid", insn_valid, 0);
        check("wrap_second_addr", w_addr, 16'h0000);

        // streaming one instruction per cycle
        for (int n = 1; n <= 6; n++) begin
            @(negedge clk);
            check("stream_valid", insn_valid, 1);
            check("stream_insn", insn, 32'(2 * (n - 1)));
            check("stream_ip", insn_ip, 32'(2 * (n - 1)));
            check("stream_addr", mem_addr, 32'(2 * (n + 1)));
            e = 16'hFFFE + 16'(2 * (n - 1));
            check("wrap_ip", w_insn_ip, e);
            check("wrap_insn", w_insn, e);
        end

        // stall: head 0x000A held, second slot fills, no further requests
        insn_ready = 1'b0; #1;
        check("stall_rd_now", mem_rd, 0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("stall_valid", insn_valid, 1);
            check("stall_insn", insn, 16'h000A);
            check("stall_rd", mem_rd, 0);
        end
        insn_ready = 1'b1; #1;
        check("resume_rd", mem_rd, 1);
        check("resume_addr", mem_addr, 16'h000E);
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            check("resume_valid", insn_valid, 1);
            check("resume_insn", insn, 32'(12 + 2 * j));
        end

        // redirect coincident with an ack and a valid head
        load_ip = 1'b1; new_ip = 16'h0200; #1;
        check("redir_no_issue", mem_rd, 0);
        @(negedge clk);
        load_ip = 1'b0; #1;
        check("redir_r1_valid", insn_valid, 0);
        check("redir_r1_rd", mem_rd, 1);
        check("redir_r1_addr", mem_addr, 16'h0200);
        @(negedge clk);
        check("redir_r2_valid", insn_valid, 0);
        @(negedge clk);
        check("redir_r3_valid", insn_valid, 1);
        check("redir_r3_ip", insn_ip, 16'h0200);
        check("redir_r3_insn", insn, 16'h0200);
        @(negedge clk);
        check("redir_next_ip", insn_ip, 16'h0202);

        // fill both slots, then reset asynchronously
        insn_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("full_valid", insn_valid, 1);
        check("full_insn", insn, 16'h0202);
        check("full_rd", mem_rd, 0);
        rst_n = 1'b0; #1;
        check("async_valid", insn_valid, 0);
        check("async_rd", mem_rd, 0);
        check("async_insn_ip", insn_ip, 0);
        check("async_addr", mem_addr, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1; insn_ready = 1'b1; #1;
        check("restart_rd", mem_rd, 1);
        check("restart_addr", mem_addr, 16'h0000);
        @(negedge clk);
        check("restart_addr2", mem_addr, 16'h0002);
        @(negedge clk);
        check("restart_valid", insn_valid, 1);
        check("restart_ip", insn_ip, 16'h0000);

        // two outstanding requests flushed by a redirect, 2-cycle memory
        rst_n = 1'b0; lat2 = 1'b1;
        @(negedge clk);
        rst_n = 1'b1; #1;
        check("l2_first_rd", mem_rd, 1);
        @(negedge clk);
        check("l2_addr2", mem_addr, 16'h0002);
        check("l2_rd2", mem_rd, 1);
        @(negedge clk);
        check("l2_full_rd", mem_rd, 0);
        load_ip = 1'b1; new_ip = 16'h0101;
        @(negedge clk);
        load_ip = 1'b0; #1;
        check("drop_valid0", insn_valid, 0);
        check("drop_rd", mem_rd, 1);
        check("drop_addr", mem_addr, 16'h0100);
        @(negedge clk);
        check("drop_valid1", insn_valid, 0);
        check("drop_addr2", mem_addr, 16'h0102);
        @(negedge clk);
        check("drop_valid2", insn_valid, 0);
        check("drop_rd_full", mem_rd, 0);
        @(negedge clk);
        check("drop_first_valid", insn_valid, 1);
        check("drop_first_ip", insn_ip, 16'h0100);
        check("drop_first_insn", insn, 16'h0100);
        @(negedge clk);
        check("drop_second_ip", insn_ip, 16'h0102);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
